// File: rtl/noc_pkg.sv
// Shared NoC types and default dimensions for the crossbar input stage.
// Consumers: sync_fifo, input_port_mcast (optional stats via INPORT_STATS_EN).
package noc_pkg;

    localparam int NOC_PORTS = 2;
    localparam int NOC_WIDTH = 8;
    localparam int NOC_DEPTH = 4;

    typedef logic [NOC_PORTS-1:0] dest_mask_t;

    // Destination mask sits in the upper bits of a stored entry.
    typedef struct packed {
        dest_mask_t           dest;
        logic [NOC_WIDTH-1:0] data;
    } flit_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty, a zeroed head when empty,
// and a lookahead of the top PEEK_W bits of the entry behind the head.
module sync_fifo
    import noc_pkg::*;
#(
    parameter int W      = NOC_PORTS + NOC_WIDTH,
    parameter int DEPTH  = NOC_DEPTH,
    parameter int PEEK_W = NOC_PORTS,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [W-1:0]      wr_data,
    input  logic              pop,
    output logic [W-1:0]      head,
    output logic [PEEK_W-1:0] next_hi,
    output logic [CW-1:0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nx;

    assign rd_ptr_nx = rd_ptr + AW'(1);
    assign head      = (count != '0) ? mem[rd_ptr] : '0;
    assign next_hi   = mem[rd_ptr_nx][W-1 -: PEEK_W];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_port_mcast.sv
// Crossbar input stage: buffers flits, presents the head with its remaining
// multicast mask, retires once all outputs served. Macro INPORT_STATS_EN adds stats.
module input_port_mcast
    import noc_pkg::*;
#(
    parameter int PORTS = NOC_PORTS,
    parameter int WIDTH = NOC_WIDTH,
    parameter int DEPTH = NOC_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [PORTS-1:0]             in_dest,
    output logic [WIDTH-1:0]             data_o,
    output logic [PORTS-1:0]             dest,
    input  logic [PORTS-1:0]             ack,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef INPORT_STATS_EN
    ,
    output logic [15:0]                  stat_flits,
    output logic [15:0]                  stat_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PORTS-1:0] dest;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           wr_e;
    entry_t           head_e;
    logic [PORTS-1:0] next_dest;
    logic [PORTS-1:0] rem;
    logic             nonempty;
    logic             push;
    logic             retire;

    // Handshake: a flit transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on reset and fill level, never on ack.
    assign in_ready = rst_n && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready && (in_dest != '0);
    assign nonempty = (count != '0);
    assign retire   = nonempty && ((rem & ~ack) == '0);
    assign wr_e     = '{dest: in_dest, data: in_data};

    sync_fifo #(
        .W      (PORTS + WIDTH),
        .DEPTH  (DEPTH),
        .PEEK_W (PORTS),
        .CW     (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_e),
        .pop     (retire),
        .head    (head_e),
        .next_hi (next_dest),
        .count   (count)
    );

    // rem loads a fresh mask whenever a new flit becomes head; otherwise it only sheds bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (retire) begin
            if (count > CW'(1)) rem <= next_dest;
            else if (push)      rem <= in_dest;
            else                rem <= '0;
        end else if (!nonempty) begin
            if (push) rem <= in_dest;
        end else begin
            rem <= rem & ~ack;
        end
    end

    assign data_o = head_e.data;
    assign dest   = rem;

`ifdef INPORT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_flits <= '0;
            stat_stall <= '0;
        end else begin
            if (retire && stat_flits != 16'hFFFF)
                stat_flits <= stat_flits + 16'd1;
            if (nonempty && ((ack & rem) == '0) && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count < CW'(DEPTH)));
    a_no_ack_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !nonempty |-> (ack == '0));
    a_rem_no_gain: assert property (@(posedge clk) disable iff (!rst_n)
        (nonempty && !retire) |=> ((rem & ~$past(rem)) == '0));

endmodule

// File: tb/tb_input_port_mcast.sv
// Bench for input_port_mcast: vector table, hand sequences, random vs queue model.
module tb_input_port_mcast;

    localparam int PORTS = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [PORTS-1:0] in_dest = '0;
    logic [WIDTH-1:0] data_o;
    logic [PORTS-1:0] dest;
    logic [PORTS-1:0] ack = '0;
    logic [CW-1:0]    count;
`ifdef INPORT_STATS_EN
    logic [15:0]      stat_flits;
    logic [15:0]      stat_stall;
`endif

    always #5 clk = ~clk;

    input_port_mcast #(.PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .data_o   (data_o),
        .dest     (dest),
        .ack      (ack),
        .count    (count)
`ifdef INPORT_STATS_EN
        ,
        .stat_flits (stat_flits),
        .stat_stall (stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of flits, the front entry's mask is what is still owed.
    typedef struct {
        logic [PORTS-1:0] dest;
        logic [WIDTH-1:0] data;
    } mflit_t;
    mflit_t mq[$];

    task automatic model_edge(input logic v, input logic [WIDTH-1:0] d,
                              input logic [PORTS-1:0] m, input logic [PORTS-1:0] a);
        bit accept;
        accept = v && (mq.size() < DEPTH) && (m != 0);
        if (mq.size() > 0) begin
            if ((mq[0].dest & ~a) == 0) void'(mq.pop_front());
            else mq[0].dest = mq[0].dest & ~a;
        end
        if (accept) mq.push_back('{dest: m, data: d});
    endtask

    // Drive at negedge, advance one rising edge, return at the following negedge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic [PORTS-1:0] m, input logic [PORTS-1:0] a);
        in_valid = v;
        in_data  = d;
        in_dest  = m;
        ack      = a;
        @(posedge clk);
        model_edge(v, d, m, a);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_dest  = '0;
        in_data  = '0;
        ack      = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", in_ready, 0);
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] data;
        logic [PORTS-1:0] dst;
        logic [PORTS-1:0] a;
        logic [CW-1:0]    e_cnt;
        logic [PORTS-1:0] e_dest;
        logic [WIDTH-1:0] e_data;
        logic             e_rdy;
    } vec_t;
    vec_t tv[22];

    initial begin
        // unicast
        tv[0]  = '{1'b1, 8'hA5, 2'b01, 2'b00, 3'd1, 2'b01, 8'hA5, 1'b1};
        tv[1]  = '{1'b0, 8'h00, 2'b00, 2'b01, 3'd0, 2'b00, 8'h00, 1'b1};
        // partial multicast
        tv[2]  = '{1'b1, 8'h3C, 2'b11, 2'b00, 3'd1, 2'b11, 8'h3C, 1'b1};
        tv[3]  = '{1'b0, 8'h00, 2'b00, 2'b10, 3'd1, 2'b01, 8'h3C, 1'b1};
        tv[4]  = '{1'b0, 8'h00, 2'b00, 2'b00, 3'd1, 2'b01, 8'h3C, 1'b1};
        tv[5]  = '{1'b0, 8'h00, 2'b00, 2'b01, 3'd0, 2'b00, 8'h00, 1'b1};
        // fill and backpressure
        tv[6]  = '{1'b1, 8'h11, 2'b01, 2'b00, 3'd1, 2'b01, 8'h11, 1'b1};
        tv[7]  = '{1'b1, 8'h22, 2'b10, 2'b00, 3'd2, 2'b01, 8'h11, 1'b1};
        tv[8]  = '{1'b1, 8'h33, 2'b11, 2'b00, 3'd3, 2'b01, 8'h11, 1'b1};
        tv[9]  = '{1'b1, 8'h44, 2'b01, 2'b00, 3'd4, 2'b01, 8'h11, 1'b0};
        tv[10] = '{1'b1, 8'h55, 2'b10, 2'b01, 3'd3, 2'b10, 8'h22, 1'b1};
        tv[11] = '{1'b1, 8'h55, 2'b10, 2'b10, 3'd3, 2'b11, 8'h33, 1'b1};
        tv[12] = '{1'b0, 8'h00, 2'b00, 2'b11, 3'd2, 2'b01, 8'h44, 1'b1};
        tv[13] = '{1'b0, 8'h00, 2'b00, 2'b01, 3'd1, 2'b10, 8'h55, 1'b1};
        tv[14] = '{1'b0, 8'h00, 2'b00, 2'b10, 3'd0, 2'b00, 8'h00, 1'b1};
        // zero mask and stray ack
        tv[15] = '{1'b1, 8'h66, 2'b00, 2'b00, 3'd0, 2'b00, 8'h00, 1'b1};
        tv[16] = '{1'b1, 8'h77, 2'b01, 2'b00, 3'd1, 2'b01, 8'h77, 1'b1};
        tv[17] = '{1'b0, 8'h00, 2'b00, 2'b10, 3'd1, 2'b01, 8'h77, 1'b1};
        tv[18] = '{1'b0, 8'h00, 2'b00, 2'b01, 3'd0, 2'b00, 8'h00, 1'b1};
        // retire and push into the emptied FIFO in one cycle
        tv[19] = '{1'b1, 8'h88, 2'b10, 2'b00, 3'd1, 2'b10, 8'h88, 1'b1};
        tv[20] = '{1'b1, 8'h99, 2'b01, 2'b10, 3'd1, 2'b01, 8'h99, 1'b1};
        tv[21] = '{1'b0, 8'h00, 2'b00, 2'b01, 3'd0, 2'b00, 8'h00, 1'b1};

        @(negedge clk);
        do_reset();
        check("rst_count", count, 0);
        check("rst_dest", dest, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", in_ready, 1);

        for (int i = 0; i < 22; i++) begin
            step(tv[i].v, tv[i].data, tv[i].dst, tv[i].a);
            check($sformatf("vec%0d_count", i), count, tv[i].e_cnt);
            check($sformatf("vec%0d_dest", i), dest, tv[i].e_dest);
            check($sformatf("vec%0d_data", i), data_o, tv[i].e_data);
            check($sformatf("vec%0d_ready", i), in_ready, tv[i].e_rdy);
        end

        // asynchronous reset with three flits queued and head partially served
        do_reset();
        step(1'b1, 8'hA1, 2'b11, 2'b00);
        step(1'b1, 8'hA2, 2'b01, 2'b00);
        step(1'b1, 8'hA3, 2'b10, 2'b01);
        check("mid_pre_dest", dest, 2'b10);
        check("mid_pre_count", count, 3);
        in_valid = 1'b0;
        ack      = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dest", dest, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
        step(1'b1, 8'hC3, 2'b01, 2'b00);
        check("post_rst_dest", dest, 2'b01);
        check("post_rst_data", data_o, 8'hC3);
        check("post_rst_count", count, 1);

        // randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic             v;
            logic [WIDTH-1:0] d;
            logic [PORTS-1:0] m;
            logic [PORTS-1:0] a;
            v = ($urandom_range(0, 3) != 0);
            d = WIDTH'($urandom_range(0, 255));
            m = PORTS'($urandom_range(0, 3));
            a = (mq.size() > 0) ? PORTS'($urandom_range(0, 3)) : '0;
            in_valid = v;
            in_data  = d;
            in_dest  = m;
            ack      = a;
            #1;
            check("rnd_ready", in_ready, (mq.size() < DEPTH));
            step(v, d, m, a);
            check("rnd_count", count, mq.size());
            check("rnd_dest", dest, (mq.size() > 0) ? mq[0].dest : 2'b00);
            check("rnd_data", data_o, (mq.size() > 0) ? mq[0].data : 8'h00);
        end

`ifdef INPORT_STATS_EN
        do_reset();
        check("stat_rst_flits", stat_flits, 0);
        check("stat_rst_stall", stat_stall, 0);
        step(1'b1, 8'h01, 2'b01, 2'b00);
        repeat (7) step(1'b0, 8'h00, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b1, 8'(k + 2), 2'b01, 2'b01);
        step(1'b0, 8'h00, 2'b00, 2'b01);
        check("stat_flits5", stat_flits, 5);
        check("stat_stall7", stat_stall, 7);
        step(1'b1, 8'hEE, 2'b10, 2'b00);
        repeat (65535) step(1'b0, 8'h00, 2'b00, 2'b00);
        check("stat_stall_sat", stat_stall, 16'hFFFF);
        check("stat_flits_hold", stat_flits, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
